branch_resolve_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle branch comparator.
- Resolves conditional branches, JAL and JALR, computes the target, and checks the front-end prediction.
- Emits mispredict and redirect_pc to the fetch stage.
- Sits at the EX stage boundary behind a valid/ready handshake, with flush support and saturating performance counters.

---
 rtl/rv32i_types.sv | 46 ++++
 rtl/cmp_param.sv | 45 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/branch_resolve_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_branch_resolve_pipe.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared RV32I control-transfer types used by the branch resolution logic.
//   branch_funct3_t : B-type funct3 condition encodings (010/011 are reserved)
//   br_kind_t       : class of control transfer presented to the resolver
//   br_stage_t      : rv32 layout of one in-flight resolver entry
// -----------------------------------------------------------------------------
package rv32i_types;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } br_kind_t;

    // The resolver keeps a WIDTH-sized copy of this record; this is the
    // fixed rv32 shape for neighbouring blocks that trace or log entries.
    typedef struct packed {
        logic                valid;
        br_kind_t            kind;
        logic                taken;
        logic                illegal;
        logic [XLEN-1:0]     target;
        logic [XLEN-1:0]     pc_plus4;
        logic                pred_taken;
        logic [XLEN-1:0]     pred_target;
    } br_stage_t;

    // True for the two funct3 codes that have no branch meaning.
    function automatic logic funct3_reserved(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/cmp_param.sv
// -----------------------------------------------------------------------------
// cmp_param
// Combinational branch-direction compare of width WIDTH.
//   cmpop   : funct3 condition
//   a, b    : rs1 / rs2 operands
//   taken   : condition holds
//   illegal : cmpop is a reserved encoding (taken forced to 0)
// -----------------------------------------------------------------------------
module cmp_param
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  branch_funct3_t     cmpop,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               taken,
    output logic               illegal
);

    logic taken_s;
    logic illegal_s;

    // Evaluate the selected condition; reserved codes fall to the default arm.
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        case (cmpop)
            F3_BEQ:  taken_s = (a == b);
            F3_BNE:  taken_s = (a != b);
            F3_BLT:  taken_s = ($signed(a) <  $signed(b));
            F3_BGE:  taken_s = ($signed(a) >= $signed(b));
            F3_BLTU: taken_s = (a <  b);
            F3_BGEU: taken_s = (a >= b);
            default: begin
                taken_s   = 1'b0;
                illegal_s = funct3_reserved(cmpop);
            end
        endcase
    end

    assign taken   = taken_s;
    assign illegal = illegal_s;

endmodule

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Generic saturating event counter for performance monitors.
//   clk, rst : clock, synchronous active-high clear
//   inc      : count one event this cycle
//   count    : current value, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [W-1:0]  count
);

    localparam logic [W-1:0] ONE = W'(1'b1);

    logic [W-1:0] count_r;

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/branch_resolve_pipe.sv
// -----------------------------------------------------------------------------
// branch_resolve_pipe
// Pipelined branch / JAL / JALR resolver at the EX boundary. Computes the
// direction and target, checks the front-end prediction, and reports the
// correct next PC to fetch. Latency is STAGES (1 or 2) cycles.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : request handshake (in_ready is combinational)
//   kind, cmpop, a, b, pc,
//   imm, pred_taken,
//   pred_target              : request fields
//   flush                    : drop every in-flight entry and same-cycle input
//   out_valid / out_ready    : result handshake
//   taken, target,
//   redirect_pc, mispredict,
//   illegal                  : registered result fields
//   br_count, mispred_count  : saturating counters, bumped on output handshake
// -----------------------------------------------------------------------------
module branch_resolve_pipe
    import rv32i_types::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  br_kind_t           kind,
    input  branch_funct3_t     cmpop,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   imm,
    input  logic               pred_taken,
    input  logic [WIDTH-1:0]   pred_target,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               taken,
    output logic [WIDTH-1:0]   target,
    output logic [WIDTH-1:0]   redirect_pc,
    output logic               mispredict,
    output logic               illegal,
    output logic [CNT_W-1:0]   br_count,
    output logic [CNT_W-1:0]   mispred_count
);

    localparam logic [WIDTH-1:0] FOUR_C      = WIDTH'(3'd4);
    localparam logic [WIDTH-1:0] JALR_MASK_C = {{(WIDTH-1){1'b1}}, 1'b0};

    // WIDTH-sized twin of rv32i_types::br_stage_t.
    typedef struct packed {
        logic                valid;
        br_kind_t            kind;
        logic                taken;
        logic                illegal;
        logic [WIDTH-1:0]    target;
        logic [WIDTH-1:0]    pc_plus4;
        logic                pred_taken;
        logic [WIDTH-1:0]    pred_target;
    } stage_t;

    logic               cmp_taken_s;
    logic               cmp_illegal_s;
    logic [WIDTH-1:0]   pc_plus4_s;
    logic [WIDTH-1:0]   pc_imm_s;
    logic [WIDTH-1:0]   jalr_sum_s;
    stage_t             s1_s;
    stage_t             s2_in_s;
    logic [WIDTH-1:0]   redirect_s;
    logic               mispredict_s;
    logic               out_load_s;
    logic               out_fire_s;
    logic               br_inc_s;
    logic               mis_inc_s;

    logic               out_valid_r;
    br_kind_t           kind_r;
    logic               taken_r;
    logic [WIDTH-1:0]   target_r;
    logic [WIDTH-1:0]   redirect_r;
    logic               mispredict_r;
    logic               illegal_r;

    cmp_param #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .cmpop   (cmpop),
        .a       (a),
        .b       (b),
        .taken   (cmp_taken_s),
        .illegal (cmp_illegal_s)
    );

    // All adders wrap modulo 2^WIDTH.
    assign pc_plus4_s = pc + FOUR_C;
    assign pc_imm_s   = pc + imm;
    assign jalr_sum_s = a + imm;

    // Stage 1: direction and target per transfer kind.
    always_comb begin
        s1_s             = '0;
        s1_s.valid       = in_valid;
        s1_s.kind        = kind;
        s1_s.pc_plus4    = pc_plus4_s;
        s1_s.pred_taken  = pred_taken;
        s1_s.pred_target = pred_target;
        case (kind)
            BR_COND: begin
                s1_s.taken   = cmp_taken_s;
                s1_s.illegal = cmp_illegal_s;
                s1_s.target  = pc_imm_s;
            end
            BR_JAL: begin
                s1_s.taken  = 1'b1;
                s1_s.target = pc_imm_s;
            end
            BR_JALR: begin
                s1_s.taken  = 1'b1;
                s1_s.target = jalr_sum_s & JALR_MASK_C;
            end
            BR_NONE: begin
                s1_s.taken  = 1'b0;
                s1_s.target = pc_plus4_s;
            end
            default: begin
                s1_s.taken  = 1'b0;
                s1_s.target = pc_plus4_s;
            end
        endcase
    end

    // The output register can take a new entry when empty or being drained.
    assign out_load_s = !out_valid_r || out_ready;

    generate
        if (STAGES == 2) begin : g_two_stage
            stage_t s1_r;
            logic   s1_ready_s;

            assign s1_ready_s = !s1_r.valid || out_load_s;

            // Stage-1 register: advances whenever downstream has room.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_r <= '0;
                end else if (flush) begin
                    s1_r.valid <= 1'b0;
                end else if (s1_ready_s) begin
                    s1_r <= s1_s;
                end else begin
                    s1_r <= s1_r;
                end
            end

            assign s2_in_s  = s1_r;
            assign in_ready = s1_ready_s;
        end else begin : g_one_stage
            assign s2_in_s  = s1_s;
            assign in_ready = out_load_s;
        end
    endgenerate

    // Stage 2: next-PC selection and prediction check.
    always_comb begin
        redirect_s   = s2_in_s.pc_plus4;
        mispredict_s = 1'b0;
        if (s2_in_s.taken) begin
            redirect_s   = s2_in_s.target;
            mispredict_s = !s2_in_s.pred_taken ||
                           (s2_in_s.target != s2_in_s.pred_target);
        end else begin
            redirect_s   = s2_in_s.pc_plus4;
            mispredict_s = s2_in_s.pred_taken;
        end
    end

    // Output register: fields only change when a new valid entry lands, so
    // they hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            kind_r       <= BR_NONE;
            taken_r      <= 1'b0;
            target_r     <= '0;
            redirect_r   <= '0;
            mispredict_r <= 1'b0;
            illegal_r    <= 1'b0;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
        end else if (out_load_s) begin
            out_valid_r <= s2_in_s.valid;
            if (s2_in_s.valid) begin
                kind_r       <= s2_in_s.kind;
                taken_r      <= s2_in_s.taken;
                target_r     <= s2_in_s.target;
                redirect_r   <= redirect_s;
                mispredict_r <= mispredict_s;
                illegal_r    <= s2_in_s.illegal;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Counters see the consumed result, including one consumed during flush.
    assign out_fire_s = out_valid_r && out_ready;
    assign br_inc_s   = out_fire_s && (kind_r != BR_NONE);
    assign mis_inc_s  = out_fire_s && mispredict_r;

    sat_counter #(
        .W (CNT_W)
    ) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_inc_s),
        .count (br_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_mis_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mis_inc_s),
        .count (mispred_count)
    );

    assign out_valid   = out_valid_r;
    assign taken       = taken_r;
    assign target      = target_r;
    assign redirect_pc = redirect_r;
    assign mispredict  = mispredict_r;
    assign illegal     = illegal_r;

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_pipe
// Three resolver builds share the request fields: index 0 is STAGES=1,
// index 1 is STAGES=2, index 2 is STAGES=1 with 4-bit counters. Only one
// build is driven with in_valid at a time.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_resolve_pipe;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    br_kind_t       kind;
    branch_funct3_t cmpop;
    logic [31:0]    a, b, pc, imm, pred_target;
    logic           pred_taken, flush;

    logic        iv[3], ir[3], ov[3], ordy[3], tk[3], mp[3], il[3];
    logic [31:0] tg[3], rp[3];
    logic [31:0] bc[2], mc[2];
    logic [3:0]  bc4, mc4;

    branch_resolve_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(32)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .kind(kind), .cmpop(cmpop),
        .a(a), .b(b), .pc(pc), .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
        .flush(flush), .out_valid(ov[0]), .out_ready(ordy[0]), .taken(tk[0]), .target(tg[0]),
        .redirect_pc(rp[0]), .mispredict(mp[0]), .illegal(il[0]), .br_count(bc[0]), .mispred_count(mc[0]));

    branch_resolve_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(32)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .kind(kind), .cmpop(cmpop),
        .a(a), .b(b), .pc(pc), .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
        .flush(flush), .out_valid(ov[1]), .out_ready(ordy[1]), .taken(tk[1]), .target(tg[1]),
        .redirect_pc(rp[1]), .mispredict(mp[1]), .illegal(il[1]), .br_count(bc[1]), .mispred_count(mc[1]));

    branch_resolve_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .kind(kind), .cmpop(cmpop),
        .a(a), .b(b), .pc(pc), .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
        .flush(flush), .out_valid(ov[2]), .out_ready(ordy[2]), .taken(tk[2]), .target(tg[2]),
        .redirect_pc(rp[2]), .mispredict(mp[2]), .illegal(il[2]), .br_count(bc4), .mispred_count(mc4));

    typedef struct packed {
        br_kind_t    kind;
        logic        taken;
        logic [31:0] target;
        logic [31:0] redirect;
        logic        mis;
        logic        ill;
    } exp_t;

    typedef struct {
        br_kind_t    kind;
        logic [2:0]  op;
        logic [31:0] a, b, pc, imm;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_tk;
        logic [31:0] e_tg, e_rp;
        logic        e_mp, e_il;
    } vec_t;

    vec_t  tv[13];
    exp_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_bc[3];
    int    exp_mc[3];
    int    sent;
    logic  last_ir, last_acc, ir_dropped;
    logic  hold_pend = 1'b0;
    logic [66:0] hold_snap;
    logic [31:0] snap_bc, snap_mc;

    task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Reference behaviour written straight from the instruction semantics.
    function automatic exp_t model(input br_kind_t k, input logic [2:0] op,
                                   input logic [31:0] ra, input logic [31:0] rb,
                                   input logic [31:0] rpc, input logic [31:0] rimm,
                                   input logic pt, input logic [31:0] ptgt);
        exp_t e;
        longint sa, sb, ua, ub;
        logic [31:0] seq;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        ua = longint'({32'd0, ra});
        ub = longint'({32'd0, rb});
        seq = rpc + 32'd4;
        e.kind = k; e.taken = 1'b0; e.ill = 1'b0; e.target = seq;
        case (k)
            BR_COND: begin
                e.target = rpc + rimm;
                case (op)
                    3'b000: e.taken = (ua == ub);
                    3'b001: e.taken = (ua != ub);
                    3'b100: e.taken = (sa < sb);
                    3'b101: e.taken = (sa >= sb);
                    3'b110: e.taken = (ua < ub);
                    3'b111: e.taken = (ua >= ub);
                    default: e.ill = 1'b1;
                endcase
            end
            BR_JAL:  begin e.taken = 1'b1; e.target = rpc + rimm; end
            BR_JALR: begin e.taken = 1'b1; e.target = (ra + rimm) & 32'hFFFF_FFFE; end
            default: ;
        endcase
        e.redirect = e.taken ? e.target : seq;
        e.mis = (e.taken != pt) || (e.taken && (e.target != ptgt));
        return e;
    endfunction

    task automatic rand_req(input bit nonzero);
        exp_t e;
        kind  = nonzero ? br_kind_t'($urandom_range(1, 3)) : br_kind_t'($urandom_range(0, 3));
        cmpop = branch_funct3_t'(3'($urandom));
        a     = $urandom;
        b     = ($urandom_range(0, 3) == 0) ? a : $urandom;
        pc    = $urandom;
        imm   = $urandom;
        pred_taken = 1'($urandom);
        e = model(kind, cmpop, a, b, pc, imm, 1'b0, 32'd0);
        pred_target = ($urandom_range(0, 1) == 1) ? e.target : $urandom;
    endtask

    // One clock of scoreboard-checked traffic on build d; called at negedge.
    task automatic step(input int d);
        exp_t e;
        #1;
        last_ir  = ir[d];
        last_acc = 1'b0;
        if (hold_pend) begin
            chk("hold_stable", {tk[d], mp[d], il[d], tg[d], rp[d]}, hold_snap);
            hold_pend = 1'b0;
        end
        if (ov[d] && ordy[d]) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 72'd1, 72'd0);
            end else begin
                e = q.pop_front();
                chk("result", {tk[d], mp[d], il[d], tg[d], rp[d]},
                    {e.taken, e.mis, e.ill, e.target, e.redirect});
                exp_bc[d] += (e.kind != BR_NONE) ? 1 : 0;
                exp_mc[d] += e.mis ? 1 : 0;
            end
        end
        if (iv[d] && ir[d] && !flush) begin
            q.push_back(model(kind, cmpop, a, b, pc, imm, pred_taken, pred_target));
            last_acc = 1'b1;
        end
        if (ov[d] && !ordy[d] && !flush) begin
            hold_snap = {tk[d], mp[d], il[d], tg[d], rp[d]};
            hold_pend = 1'b1;
        end
        @(posedge clk);
        if (flush) q.delete();
        @(negedge clk);
    endtask

    task automatic drain(input int d);
        iv[d] = 1'b0; ordy[d] = 1'b1; flush = 1'b0;
        for (int k = 0; k < 8 && q.size() > 0; k++) step(d);
        chk("drain_empty", 72'(q.size()), 72'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{BR_COND, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0,   1'b1, 32'h120, 32'h120, 1'b1, 1'b0};
        tv[1]  = '{BR_COND, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0,   1'b0, 32'h120, 32'h104, 1'b0, 1'b0};
        tv[2]  = '{BR_JALR, 3'b000, 32'h2003, 32'h0, 32'h300, 32'h4, 1'b1, 32'h2006,       1'b1, 32'h2006, 32'h2006, 1'b0, 1'b0};
        tv[3]  = '{BR_JALR, 3'b000, 32'h2003, 32'h0, 32'h300, 32'h4, 1'b1, 32'h2008,       1'b1, 32'h2006, 32'h2006, 1'b1, 1'b0};
        tv[4]  = '{BR_COND, 3'b010, 32'h5, 32'h5, 32'h40, 32'h8, 1'b0, 32'h0,              1'b0, 32'h48, 32'h44, 1'b0, 1'b1};
        tv[5]  = '{BR_NONE, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0,       1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
        tv[6]  = '{BR_NONE, 3'b000, 32'h0, 32'h0, 32'h10, 32'h0, 1'b1, 32'h0,              1'b0, 32'h14, 32'h14, 1'b1, 1'b0};
        tv[7]  = '{BR_COND, 3'b000, 32'h7, 32'h7, 32'h1000, 32'hFFFF_FFF0, 1'b1, 32'hFF0,  1'b1, 32'hFF0, 32'hFF0, 1'b0, 1'b0};
        tv[8]  = '{BR_JAL,  3'b000, 32'h0, 32'h0, 32'h80, 32'h100, 1'b0, 32'h0,            1'b1, 32'h180, 32'h180, 1'b1, 1'b0};
        tv[9]  = '{BR_COND, 3'b101, 32'h8000_0000, 32'h0, 32'h200, 32'h10, 1'b0, 32'h0,    1'b0, 32'h210, 32'h204, 1'b0, 1'b0};
        tv[10] = '{BR_COND, 3'b111, 32'h8000_0000, 32'h0, 32'h200, 32'h10, 1'b1, 32'h210,  1'b1, 32'h210, 32'h210, 1'b0, 1'b0};
        tv[11] = '{BR_COND, 3'b001, 32'h1, 32'h2, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'h0,       1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0};
        tv[12] = '{BR_COND, 3'b011, 32'h0, 32'h0, 32'h8, 32'h4, 1'b1, 32'hC,               1'b0, 32'hC, 32'hC, 1'b1, 1'b1};

        rst = 1'b1; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; exp_bc[i] = 0; exp_mc[i] = 0; end
        kind = BR_NONE; cmpop = F3_BEQ; a = '0; b = '0; pc = '0; imm = '0;
        pred_taken = 1'b0; pred_target = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", {ov[0], ov[1], ov[2]}, 3'b000);
        chk("rst_counters", {bc[0], mc[0], bc[1], mc[1]}, 128'd0);
        chk("rst_c4_counters", {bc4, mc4}, 8'd0);
        chk("rst_fields", {tk[0], mp[0], il[0], tg[0], rp[0]}, 67'd0);

        // Directed vectors on the single-stage build
        for (int i = 0; i < 13; i++) begin
            kind = tv[i].kind; cmpop = branch_funct3_t'(tv[i].op);
            a = tv[i].a; b = tv[i].b; pc = tv[i].pc; imm = tv[i].imm;
            pred_taken = tv[i].pt; pred_target = tv[i].ptgt;
            iv[0] = 1'b1; ordy[0] = 1'b1;
            #1 chk("vec_in_ready", 72'(ir[0]), 72'd1);
            @(posedge clk);
            @(negedge clk);
            iv[0] = 1'b0;
            chk($sformatf("vec%0d_valid", i), 72'(ov[0]), 72'd1);
            chk($sformatf("vec%0d_fields", i), {tk[0], mp[0], il[0], tg[0], rp[0]},
                {tv[i].e_tk, tv[i].e_mp, tv[i].e_il, tv[i].e_tg, tv[i].e_rp});
            chk($sformatf("vec%0d_counts", i), {bc[0], mc[0]}, {32'(exp_bc[0]), 32'(exp_mc[0])});
            exp_bc[0] += (tv[i].kind != BR_NONE) ? 1 : 0;
            exp_mc[0] += tv[i].e_mp ? 1 : 0;
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("vec_final_counts", {bc[0], mc[0]}, {32'd11, 32'd6});

        // Two-stage build: 8 requests with a 3-cycle consumer stall mid-stream
        sent = 0; ir_dropped = 1'b0; hold_pend = 1'b0;
        for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
            iv[1] = (sent < 8);
            rand_req(1'b1);
            ordy[1] = !(c >= 3 && c < 6);
            step(1);
            if (last_acc) sent++;
            if (!last_ir) ir_dropped = 1'b1;
        end
        chk("stall_sent", 72'(sent), 72'd8);
        chk("stall_in_ready_dropped", 72'(ir_dropped), 72'd1);
        chk("stall_queue_empty", 72'(q.size()), 72'd0);
        chk("stall_br_count", 72'(bc[1]), 72'd8);

        // Flush with two entries in flight and a new request alongside
        iv[1] = 1'b1; ordy[1] = 1'b0;
        rand_req(1'b1); step(1);
        rand_req(1'b1); step(1);
        snap_bc = bc[1]; snap_mc = mc[1];
        flush = 1'b1; rand_req(1'b1); step(1);
        flush = 1'b0; iv[1] = 1'b0; hold_pend = 1'b0;
        chk("flush_out_valid", 72'(ov[1]), 72'd0);
        chk("flush_counts", {bc[1], mc[1]}, {snap_bc, snap_mc});
        chk("flush_queue", 72'(q.size()), 72'd0);
        iv[1] = 1'b1; ordy[1] = 1'b1; rand_req(1'b0); step(1);
        drain(1);
        chk("post_flush_counts", {bc[1], mc[1]}, {32'(exp_bc[1]), 32'(exp_mc[1])});

        // Two-stage latency on an empty pipe
        iv[1] = 1'b1; ordy[1] = 1'b1;
        kind = BR_JAL; pc = 32'h400; imm = 32'h40; pred_taken = 1'b1; pred_target = 32'h440;
        step(1);
        iv[1] = 1'b0;
        chk("lat2_after1", 72'(ov[1]), 72'd0);
        step(1);
        chk("lat2_after2", 72'(ov[1]), 72'd1);
        drain(1);

        // Randomised traffic with occasional flushes on both depths
        for (int d = 0; d < 2; d++) begin
            hold_pend = 1'b0;
            for (int c = 0; c < 200; c++) begin
                iv[d]   = ($urandom_range(0, 9) < 7);
                ordy[d] = ($urandom_range(0, 9) < 7);
                flush   = ($urandom_range(0, 24) == 0);
                rand_req(1'b0);
                step(d);
            end
            drain(d);
            chk($sformatf("rand%0d_counts", d), {bc[d], mc[d]}, {32'(exp_bc[d]), 32'(exp_mc[d])});
        end

        // 4-bit counters saturate instead of wrapping
        for (int i = 0; i < 17; i++) begin
            iv[2] = 1'b1; ordy[2] = 1'b1;
            kind = BR_JAL; pc = 32'(i * 16); imm = 32'h8; pred_taken = 1'b0; pred_target = 32'h0;
            step(2);
            if (i == 10) chk("c4_count10", {bc4, mc4}, {4'd10, 4'd10});
        end
        drain(2);
        chk("c4_saturated", {bc4, mc4}, {4'hF, 4'hF});

        // Reset mid-operation clears the pipe and the counters
        iv[1] = 1'b1; ordy[1] = 1'b0;
        rand_req(1'b1); step(1);
        rand_req(1'b1); step(1);
        rst = 1'b1; iv[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; q.delete(); hold_pend = 1'b0;
        exp_bc[1] = 0; exp_mc[1] = 0;
        chk("midrst_out_valid", 72'(ov[1]), 72'd0);
        chk("midrst_counts", {bc[1], mc[1]}, 64'd0);
        chk("midrst_fields", {tk[1], mp[1], il[1], tg[1], rp[1]}, 67'd0);
        iv[1] = 1'b1; ordy[1] = 1'b1; rand_req(1'b1); step(1);
        drain(1);
        chk("midrst_resume_count", 72'(bc[1]), 72'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
